key_capture_ctrl: RTL and testbench

- Controller that sequences the switch-capture counter datapath from the board push-button.
- Synchronises and debounces the raw button, issues one-cycle capture strobes with optional auto-repeat while the button is held, and presents a stable latched switch word.
- Maintains a wrapping count of issued captures.
- Sits between key_i[0] / sw_i and the counter/display datapath, replacing direct use of the raw key.

---
 rtl/key_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_capture_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_capture_ctrl.sv
// Push-button capture controller: synchronises and debounces key_i, issues
// one-cycle capture strobes (with optional auto-repeat) and latches sw_i.
module key_capture_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_CYC     = 16,
    parameter int REPEAT_CYC   = 8,
    parameter int DATA_W       = 14
) (
    input  logic              clk100_i,
    input  logic              rstn_i,
    input  logic              key_i,
    input  logic [DATA_W-1:0] sw_i,
    input  logic              rpt_en_i,
    output logic              capture_o,
    output logic [DATA_W-1:0] data_o,
    output logic [7:0]        press_cnt_o,
    output logic [2:0]        state_o
);

    localparam int MAX_DH  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_DH > REPEAT_CYC) ? MAX_DH : REPEAT_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        DB_REL   = 3'd4
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                sync1_reg;
    logic                sync2_reg;
    logic                capture_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [7:0]          press_cnt_reg;
    logic                pressed;

    // Synchroniser flops reset to the released level so a held key after
    // reset is seen as a fresh press.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign pressed = ~sync2_reg;

    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            capture_reg   <= 1'b0;
            data_reg      <= '0;
            press_cnt_reg <= 8'd0;
        end else begin
            capture_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pressed) begin
                        state_reg <= DB_PRESS;
                        cnt_reg   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        state_reg     <= HELD;
                        cnt_reg       <= '0;
                        capture_reg   <= 1'b1;
                        data_reg      <= sw_i;
                        press_cnt_reg <= press_cnt_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_reg <= DB_REL;
                        cnt_reg   <= '0;
                    end else if (rpt_en_i) begin
                        if (cnt_reg == HOLD_LAST) begin
                            state_reg     <= REPEAT;
                            cnt_reg       <= '0;
                            capture_reg   <= 1'b1;
                            data_reg      <= sw_i;
                            press_cnt_reg <= press_cnt_reg + 8'd1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else if (cnt_reg != HOLD_LAST) begin
                        // Without repeat the hold timer parks at its last value.
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!pressed) begin
                        state_reg <= DB_REL;
                        cnt_reg   <= '0;
                    end else if (!rpt_en_i) begin
                        state_reg <= HELD;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == REP_LAST) begin
                        cnt_reg       <= '0;
                        capture_reg   <= 1'b1;
                        data_reg      <= sw_i;
                        press_cnt_reg <= press_cnt_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DB_REL: begin
                    if (pressed) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign capture_o   = capture_reg;
    assign data_o      = data_reg;
    assign press_cnt_o = press_cnt_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_key_capture_ctrl.sv
// Directed bench for key_capture_ctrl: reset, clean press, bounce rejection,
// auto-repeat, count wrap and reset in mid-sequence.
module tb_key_capture_ctrl;

    logic        clk100_i = 1'b0;
    logic        rstn_i;
    logic        key_i;
    logic [13:0] sw_i;
    logic        rpt_en_i;
    logic        capture_o;
    logic [13:0] data_o;
    logic [7:0]  press_cnt_o;
    logic [2:0]  state_o;

    int tests_run = 0;
    int tests_failed = 0;
    int edge_no = 0;
    int exp_caps[$];

    key_capture_ctrl dut (
        .clk100_i    (clk100_i),
        .rstn_i      (rstn_i),
        .key_i       (key_i),
        .sw_i        (sw_i),
        .rpt_en_i    (rpt_en_i),
        .capture_o   (capture_o),
        .data_o      (data_o),
        .press_cnt_o (press_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; prints one line per capture strobe.
    task automatic tick();
        @(posedge clk100_i);
        #1;
        edge_no++;
        if (capture_o === 1'b1)
            $display("[TB] capture at edge %0d data=0x%0h count=%0d", edge_no, data_o, press_cnt_o);
    endtask

    function automatic logic cap_expected(input int e);
        foreach (exp_caps[i])
            if (exp_caps[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    // Tick through edges first..last checking capture_o against exp_caps.
    task automatic run_check(input string tag, input int last);
        while (edge_no < last) begin
            tick();
            check_val($sformatf("%s_cap_e%0d", tag, edge_no), {31'd0, capture_o},
                      {31'd0, cap_expected(edge_no)});
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        key_i  = 1'b1;
        tick();
        rstn_i = 1'b1;
        tick();
        tick();
        edge_no = 0;
    endtask

    initial begin
        rstn_i   = 1'b0;
        key_i    = 1'b0;
        sw_i     = 14'h3FFF;
        rpt_en_i = 1'b0;

        // 1. Reset with key pressed and all switches high
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("rst_cap",   {31'd0, capture_o}, 32'd0);
            check_val("rst_data",  {18'd0, data_o}, 32'd0);
            check_val("rst_cnt",   {24'd0, press_cnt_o}, 32'd0);
            check_val("rst_state", {29'd0, state_o}, 32'd0);
        end
        rstn_i = 1'b1;
        key_i  = 1'b1;
        tick();
        tick();

        // 2. Clean press, no repeat
        do_reset();
        sw_i = 14'h01A5;
        key_i = 1'b0;
        exp_caps = '{7};
        run_check("press", 3);
        check_val("press_state_e3", {29'd0, state_o}, 32'd1);
        run_check("press", 7);
        check_val("press_state_e7", {29'd0, state_o}, 32'd2);
        check_val("press_data", {18'd0, data_o}, 32'h01A5);
        run_check("press", 30);
        check_val("press_state_e30", {29'd0, state_o}, 32'd2);
        check_val("press_cnt", {24'd0, press_cnt_o}, 32'd1);
        key_i = 1'b1;
        while (edge_no < 40) begin
            tick();
            check_val($sformatf("rel_cap_e%0d", edge_no), {31'd0, capture_o}, 32'd0);
            check_val($sformatf("rel_state_e%0d", edge_no), {29'd0, state_o},
                      (edge_no <= 32) ? 32'd2 : (edge_no <= 36) ? 32'd4 : 32'd0);
        end
        check_val("rel_data", {18'd0, data_o}, 32'h01A5);
        check_val("rel_cnt", {24'd0, press_cnt_o}, 32'd1);

        // 3. Bounce: low 3, high 1, low 2, high 2, five times
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) begin
                key_i = (c < 3 || c == 4 || c == 5) ? 1'b0 : 1'b1;
                tick();
                check_val("bounce_cap", {31'd0, capture_o}, 32'd0);
                check_val("bounce_held", {31'd0, (state_o == 3'd2)}, 32'd0);
            end
        end
        key_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("bounce_cnt", {24'd0, press_cnt_o}, 32'd0);
        check_val("bounce_state", {29'd0, state_o}, 32'd0);

        // 4. Auto-repeat with key sampled low on edges 1..50
        do_reset();
        rpt_en_i = 1'b1;
        sw_i = 14'h2BCD;
        key_i = 1'b0;
        exp_caps = '{7, 23, 31, 39, 47};
        run_check("rpt", 50);
        key_i = 1'b1;
        run_check("rpt", 60);
        check_val("rpt_cnt", {24'd0, press_cnt_o}, 32'd5);
        check_val("rpt_data", {18'd0, data_o}, 32'h2BCD);
        check_val("rpt_state", {29'd0, state_o}, 32'd0);

        // 4b. Drop repeat enable while in REPEAT
        do_reset();
        key_i = 1'b0;
        exp_caps = '{7, 23};
        run_check("drop", 27);
        check_val("drop_state_rep", {29'd0, state_o}, 32'd3);
        rpt_en_i = 1'b0;
        tick();
        check_val("drop_state_held", {29'd0, state_o}, 32'd2);
        run_check("drop", 60);
        check_val("drop_cnt", {24'd0, press_cnt_o}, 32'd2);
        key_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // 5. 256 clean presses, counter wraps
        do_reset();
        for (int p = 0; p < 256; p++) begin
            sw_i = 14'(p);
            key_i = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            check_val($sformatf("wrap_cnt_%0d", p), {24'd0, press_cnt_o}, 32'((p + 1) % 256));
            key_i = 1'b1;
            for (int i = 0; i < 8; i++) tick();
        end
        check_val("wrap_data", {18'd0, data_o}, 32'd255);
        check_val("wrap_state", {29'd0, state_o}, 32'd0);

        // 6. Reset in the middle of REPEAT with the key still held
        do_reset();
        rpt_en_i = 1'b1;
        key_i = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check_val("mid_state_rep", {29'd0, state_o}, 32'd3);
        rstn_i = 1'b0;
        tick();
        check_val("mid_rst_state", {29'd0, state_o}, 32'd0);
        check_val("mid_rst_cnt", {24'd0, press_cnt_o}, 32'd0);
        check_val("mid_rst_cap", {31'd0, capture_o}, 32'd0);
        rstn_i = 1'b1;
        edge_no = 0;
        exp_caps = '{7};
        run_check("mid", 12);
        check_val("mid_state", {29'd0, state_o}, 32'd2);
        check_val("mid_cnt", {24'd0, press_cnt_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
